// File: rtl/design_mux_pkg.sv
// Shared definitions for the design output multiplexer: register map, field positions,
// FSM states and the byte-enable merge helper.
package design_mux_pkg;

  localparam int unsigned SEL_W = 4;
  typedef logic [SEL_W-1:0] sel_t;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_SETTINGS = 8'h04;
  localparam logic [7:0] REG_SETTLE   = 8'h08;
  localparam logic [7:0] REG_STATUS   = 8'h0C;

  localparam int unsigned CTRL_SEL_LSB = 0;
  localparam int unsigned CTRL_EN_BIT  = 8;

  localparam int unsigned STAT_SEL_LSB = 0;
  localparam int unsigned STAT_RUN_BIT = 8;
  localparam int unsigned STAT_SW_BIT  = 9;
  localparam int unsigned STAT_ERR_BIT = 10;
  localparam int unsigned STAT_CNT_LSB = 16;

  typedef enum logic [1:0] {StIdle, StDrain, StRun} state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/design_mux_wb_regs.sv
// Wishbone slave for the design mux: address decode, single-cycle ack, byte-enabled
// CTRL/SETTINGS/SETTLE registers, STATUS read-back and a CTRL write pulse for the FSM.
module design_mux_wb_regs
  import design_mux_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned SETTLE_RST = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] adr,
  input  logic [31:0] dat_w,
  output logic        ack,
  output logic [31:0] dat_r,
  input  logic [31:0] status,
  output sel_t        req_sel,
  output logic        enable,
  output logic [31:0] settings,
  output logic [15:0] settle,
  output logic        ctrl_wr
);

  logic        ack_q, ctrl_wr_q, enable_q;
  logic [31:0] dat_q, settings_q, rdata;
  logic [15:0] settle_q;
  sel_t        req_sel_q;
  logic        hit, start;
  logic [7:0]  off;

  assign hit   = (adr[31:8] == BASE_ADDR[31:8]);
  assign off   = adr[7:0];
  // Undecoded accesses never start, so they are never acked.
  assign start = cyc & stb & ~ack_q & hit;

  always_comb begin
    rdata = '0;
    case (off)
      REG_CTRL: begin
        rdata[CTRL_SEL_LSB +: SEL_W] = req_sel_q;
        rdata[CTRL_EN_BIT]           = enable_q;
      end
      REG_SETTINGS: rdata = settings_q;
      REG_SETTLE:   rdata[15:0] = settle_q;
      REG_STATUS:   rdata = status;
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      ctrl_wr_q  <= 1'b0;
      dat_q      <= '0;
      req_sel_q  <= '0;
      enable_q   <= 1'b0;
      settings_q <= '0;
      settle_q   <= 16'(SETTLE_RST);
    end else begin
      ack_q     <= start;
      ctrl_wr_q <= start & we & (off == REG_CTRL);
      dat_q     <= (start & ~we) ? rdata : '0;
      if (start & we) begin
        case (off)
          REG_CTRL: begin
            if (sel[CTRL_SEL_LSB / 8]) req_sel_q <= dat_w[CTRL_SEL_LSB +: SEL_W];
            if (sel[CTRL_EN_BIT / 8])  enable_q  <= dat_w[CTRL_EN_BIT];
          end
          REG_SETTINGS: settings_q <= be_merge(settings_q, dat_w, sel);
          REG_SETTLE: begin
            if (sel[0]) settle_q[7:0]  <= dat_w[7:0];
            if (sel[1]) settle_q[15:8] <= dat_w[15:8];
          end
          default: ;
        endcase
      end
    end
  end

  assign ack      = ack_q;
  assign dat_r    = dat_q;
  assign req_sel  = req_sel_q;
  assign enable   = enable_q;
  assign settings = settings_q;
  assign settle   = settle_q;
  assign ctrl_wr  = ctrl_wr_q;

endmodule

// File: rtl/design_mux.sv
// Selects one of NUM_DESIGNS user designs onto the shared pads, sequencing every switch
// through a reset-and-tristate settle period before releasing the new design.
module design_mux
  import design_mux_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS = 4,
  parameter int unsigned IO_WIDTH    = 36,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned SETTLE_RST  = 16
) (
  input  logic                            wb_clk_i,
  input  logic                            rst_n,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [31:0]                     wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  output logic [NUM_DESIGNS-1:0]          design_rst_n,
  input  logic [NUM_DESIGNS*IO_WIDTH-1:0] io_out_designs,
  input  logic [NUM_DESIGNS*IO_WIDTH-1:0] io_oeb_designs,
  output logic [IO_WIDTH-1:0]             io_out,
  output logic [IO_WIDTH-1:0]             io_oeb,
  output logic [31:0]                     custom_settings,
  output logic [3:0]                      active_sel,
  output logic                            running
);

  sel_t        req_sel;
  logic        enable, ctrl_wr;
  logic [15:0] settle, settle_load;
  logic [31:0] status;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, count_q, count_d;
  sel_t        target_q, target_d, active_sel_q, sel_d;
  logic        sel_err_q, sel_err_d, running_q;
  logic        req_valid, target_valid;

  logic [NUM_DESIGNS-1:0] rst_q, rst_d;
  logic [IO_WIDTH-1:0]    oeb_q, oeb_d, run_out;

  design_mux_wb_regs #(
    .BASE_ADDR  (BASE_ADDR),
    .SETTLE_RST (SETTLE_RST)
  ) u_regs (
    .clk      (wb_clk_i),
    .rst_n    (rst_n),
    .cyc      (wbs_cyc_i),
    .stb      (wbs_stb_i),
    .we       (wbs_we_i),
    .sel      (wbs_sel_i),
    .adr      (wbs_adr_i),
    .dat_w    (wbs_dat_i),
    .ack      (wbs_ack_o),
    .dat_r    (wbs_dat_o),
    .status   (status),
    .req_sel  (req_sel),
    .enable   (enable),
    .settings (custom_settings),
    .settle   (settle),
    .ctrl_wr  (ctrl_wr)
  );

  assign req_valid    = (32'(req_sel) < NUM_DESIGNS);
  assign target_valid = (32'(target_q) < NUM_DESIGNS);
  // Counter runs down to zero, so load SETTLE-1; a SETTLE of 0 behaves like 1.
  assign settle_load  = (settle == 16'd0) ? 16'd0 : settle - 16'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    sel_d     = active_sel_q;
    count_d   = count_q;
    sel_err_d = sel_err_q;
    if (ctrl_wr && req_valid) sel_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!req_valid) begin
          sel_err_d = 1'b1;
        end else if (enable) begin
          state_d  = StDrain;
          cnt_d    = settle_load;
          target_d = req_sel;
        end
      end
      StDrain: begin
        if (ctrl_wr) begin
          target_d = req_sel;
          cnt_d    = settle_load;
        end else if (cnt_q == 16'd0) begin
          if (enable && target_valid) begin
            state_d = StRun;
            sel_d   = target_q;
            count_d = count_q + 16'd1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StRun: begin
        if (ctrl_wr && (req_sel != active_sel_q || !enable)) begin
          state_d  = StDrain;
          cnt_d    = settle_load;
          target_d = req_sel;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pad/reset values for the next state are registered so the mux switches cleanly.
  always_comb begin
    rst_d   = '0;
    oeb_d   = '1;
    run_out = '0;
    for (int unsigned d = 0; d < NUM_DESIGNS; d++) begin
      if (state_d == StRun && sel_t'(d) == sel_d) begin
        rst_d[d] = 1'b1;
        oeb_d    = io_oeb_designs[d*IO_WIDTH +: IO_WIDTH];
      end
      if (sel_t'(d) == active_sel_q) run_out = io_out_designs[d*IO_WIDTH +: IO_WIDTH];
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      target_q     <= '0;
      active_sel_q <= '0;
      count_q      <= '0;
      sel_err_q    <= 1'b0;
      running_q    <= 1'b0;
      rst_q        <= '0;
      oeb_q        <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      active_sel_q <= sel_d;
      count_q      <= count_d;
      sel_err_q    <= sel_err_d;
      running_q    <= (state_d == StRun);
      rst_q        <= rst_d;
      oeb_q        <= oeb_d;
    end
  end

  always_comb begin
    status = '0;
    status[STAT_SEL_LSB +: SEL_W] = active_sel_q;
    status[STAT_RUN_BIT]          = running_q;
    status[STAT_SW_BIT]           = (state_q == StDrain);
    status[STAT_ERR_BIT]          = sel_err_q;
    status[STAT_CNT_LSB +: 16]    = count_q;
  end

  assign io_out       = running_q ? run_out : '0;
  assign io_oeb       = oeb_q;
  assign design_rst_n = rst_q;
  assign active_sel   = active_sel_q;
  assign running      = running_q;

endmodule

// File: tb/tb_design_mux.sv
// Directed bench for design_mux: register access, switch sequencing, select errors,
// byte enables, decode misses and asynchronous reset.
module tb_design_mux;

  localparam int unsigned ND = 4;
  localparam int unsigned IW = 36;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]      sel = 4'h0;
  logic [31:0]     adr = '0, dat_w = '0;
  logic            ack;
  logic [31:0]     dat_o;
  logic [ND-1:0]   design_rst_n;
  logic [ND*IW-1:0] io_out_designs, io_oeb_designs;
  logic [IW-1:0]   io_out, io_oeb;
  logic [31:0]     custom_settings;
  logic [3:0]      active_sel;
  logic            running;

  int n_checks = 0;
  int n_fail   = 0;

  logic [IW-1:0] exp_out [ND];
  logic [IW-1:0] exp_oeb [ND];

  always #5 clk = ~clk;

  design_mux #(
    .NUM_DESIGNS (ND),
    .IO_WIDTH    (IW),
    .BASE_ADDR   (BASE),
    .SETTLE_RST  (16)
  ) dut (
    .wb_clk_i        (clk),
    .rst_n           (rst_n),
    .wbs_cyc_i       (cyc),
    .wbs_stb_i       (stb),
    .wbs_we_i        (we),
    .wbs_sel_i       (sel),
    .wbs_adr_i       (adr),
    .wbs_dat_i       (dat_w),
    .wbs_ack_o       (ack),
    .wbs_dat_o       (dat_o),
    .design_rst_n    (design_rst_n),
    .io_out_designs  (io_out_designs),
    .io_oeb_designs  (io_oeb_designs),
    .io_out          (io_out),
    .io_oeb          (io_oeb),
    .custom_settings (custom_settings),
    .active_sel      (active_sel),
    .running         (running)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic acked;
    @(negedge clk);
    adr = a; dat_w = d; sel = be; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check_eq("wr_ack", 64'(acked), 64'd1);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic acked);
    @(negedge clk);
    adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    acked = 1'b0;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        d = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d;
    logic        acked;
    wb_read(BASE | 32'(off), d, acked);
    check_eq(tag, {31'd0, acked, d}, {31'd0, 1'b1, exp});
  endtask

  // Called right after the ack of the CTRL write that starts a 4-cycle drain.
  task automatic expect_switch(input int d);
    logic [ND-1:0] onehot;
    onehot = '0;
    onehot[d] = 1'b1;
    @(posedge clk); #1;
    check_eq("drain_oeb", 64'(io_oeb), 64'h0_F_FFFF_FFFF);
    check_eq("drain_state", {running, design_rst_n, io_out}, '0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check_eq("drain_hold", {running, design_rst_n}, '0);
    @(posedge clk); #1;
    check_eq("run_flag", 64'(running), 64'd1);
    check_eq("run_rst_n", 64'(design_rst_n), 64'(onehot));
    check_eq("run_io_out", 64'(io_out), 64'(exp_out[d]));
    check_eq("run_io_oeb", 64'(io_oeb), 64'(exp_oeb[d]));
    check_eq("run_sel", 64'(active_sel), 64'(d));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic        acked;

    exp_out[0] = 36'h0_0000_0F00; exp_oeb[0] = 36'h0_0000_0000;
    exp_out[1] = 36'h1_1111_1111; exp_oeb[1] = 36'h0_FFFF_0000;
    exp_out[2] = 36'h2_2222_2222; exp_oeb[2] = 36'h0_0000_FFFF;
    exp_out[3] = 36'h3_3333_3333; exp_oeb[3] = 36'hF_0000_0000;
    io_out_designs = {exp_out[3], exp_out[2], exp_out[1], exp_out[0]};
    io_oeb_designs = {exp_oeb[3], exp_oeb[2], exp_oeb[1], exp_oeb[0]};

    do_reset();
    #1;
    check_eq("rst_oeb", 64'(io_oeb), 64'h0_F_FFFF_FFFF);
    check_eq("rst_outs", {running, design_rst_n, io_out, active_sel}, '0);
    check_eq("rst_settings", 64'(custom_settings), 64'd0);
    read_chk("rst_status", 8'h0C, 32'h0000_0000);
    read_chk("rst_settle", 8'h08, 32'h0000_0010);

    // First enable onto design 2
    wb_write(BASE | 32'h08, 32'd4, 4'hF);
    wb_write(BASE | 32'h00, 32'h102, 4'hF);
    expect_switch(2);
    read_chk("status_d2", 8'h0C, 32'h0001_0102);

    // Switch to design 1, then a same-select rewrite is a no-op
    wb_write(BASE | 32'h00, 32'h101, 4'hF);
    expect_switch(1);
    read_chk("status_d1", 8'h0C, 32'h0002_0101);
    wb_write(BASE | 32'h00, 32'h101, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    check_eq("noop_run", {running, active_sel}, {1'b1, 4'd1});

    // Rewrite mid-drain restarts the full settle count
    wb_write(BASE | 32'h00, 32'h103, 4'hF);
    @(posedge clk); #1;
    check_eq("mid_drain", 64'(running), 64'd0);
    wb_write(BASE | 32'h00, 32'h103, 4'hF);
    expect_switch(3);
    read_chk("status_d3", 8'h0C, 32'h0003_0103);

    // Byte enables, unmapped offset, undecoded address
    wb_write(BASE | 32'h04, 32'hDEAD_BEEF, 4'b0101);
    read_chk("settings_be", 8'h04, 32'h00AD_00EF);
    check_eq("custom_settings", 64'(custom_settings), 64'h00AD_00EF);
    read_chk("ctrl_rb", 8'h00, 32'h0000_0103);
    read_chk("unmapped", 8'h10, 32'h0000_0000);
    wb_read(32'h3000_0100, d, acked);
    check_eq("nodecode_ack", 64'(acked), 64'd0);

    // Asynchronous reset while running
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", {running, design_rst_n, io_out}, '0);
    check_eq("async_oeb", 64'(io_oeb), 64'h0_F_FFFF_FFFF);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("async_settings", 64'(custom_settings), 64'd0);

    // Invalid select stays idle with sel_err, then a valid write clears it
    wb_write(BASE | 32'h08, 32'd4, 4'hF);
    wb_write(BASE | 32'h00, 32'h10F, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    check_eq("bad_sel_idle", 64'(running), 64'd0);
    read_chk("status_err", 8'h0C, 32'h0000_0400);
    wb_write(BASE | 32'h00, 32'h100, 4'hF);
    expect_switch(0);
    read_chk("status_d0", 8'h0C, 32'h0001_0100);

    // Reset in the middle of a drain
    wb_write(BASE | 32'h00, 32'h102, 4'hF);
    @(posedge clk); #1;
    check_eq("drain_from_run", {running, design_rst_n}, '0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("drain_rst", {running, design_rst_n, io_out}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("post_rst_idle", 64'(running), 64'd0);
    read_chk("post_rst_status", 8'h0C, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/design_mux.md
# design_mux

Parametrised successor to the fixed three-design output multiplexer. It selects one of `NUM_DESIGNS` user designs to own the shared GPIO bank and exposes a Wishbone register file for the select, per-design custom settings and status. It sequences every design switch safely: the old design is put in reset, the pads are tri-stated for a programmable settle period, then the new design is released. It sits between the Wishbone slave port and the design instances, next to the user wrapper's pad wiring.

## Interface
Parameters:
- `NUM_DESIGNS`, 4: number of selectable designs, 2..16.
- `IO_WIDTH`, 36: pad bits per design.
- `BASE_ADDR`, 32'h3000_0000: register block base; bits [7:0] must be 0.
- `SETTLE_RST`, 16: reset value of the SETTLE register.

Ports:
- `wb_clk_i`  in  1: sole clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each: Wishbone classic strobes.
- `wbs_sel_i`  in  4: write byte enables.
- `wbs_adr_i`, `wbs_dat_i`  in  32: address and write data.
- `wbs_ack_o`  out  1: access acknowledge.
- `wbs_dat_o`  out  32: read data.
- `design_rst_n`  out  NUM_DESIGNS: per-design active-low reset.
- `io_out_designs`, `io_oeb_designs`  in  NUM_DESIGNS*IO_WIDTH: design d occupies bits [d*IO_WIDTH +: IO_WIDTH].
- `io_out`, `io_oeb`  out  IO_WIDTH: pad drive and pad output-enable-bar.
- `custom_settings`  out  32: configuration word shared by all designs.
- `active_sel`  out  4: index of the design currently running.
- `running`  out  1: high only in RUN.

## Operation
Register map (offset from BASE_ADDR):
- 0x00 CTRL, RW: [3:0] `req_sel`; [8] `enable`.
- 0x04 SETTINGS, RW: drives `custom_settings`.
- 0x08 SETTLE, RW: [15:0] settle length in cycles; 0 is treated as 1.
- 0x0C STATUS, RO: [3:0] `active_sel`; [8] running; [9] switching; [10] `sel_err`; [31:16] switch count.

Wishbone rules:
- An access is decoded when `adr[31:8] == BASE_ADDR[31:8]`. Accesses that do not decode are never acked.
- Decoded offsets other than the four above read 0 and ignore writes.
- Writes honour `wbs_sel_i` per byte.

FSM states are IDLE, DRAIN, RUN. Reset enters IDLE.
- **IDLE:** all `design_rst_n` = 0; `io_out` = 0; `io_oeb` = all 1.
  - If `enable` = 1 and `req_sel` < NUM_DESIGNS: load the settle counter and go to DRAIN.
  - If `req_sel` ≥ NUM_DESIGNS: set `sel_err` and stay in IDLE.
- **DRAIN:** all resets asserted; pads tri-stated; counter decrements each cycle.
  - A CTRL write during DRAIN relatches the target and reloads the counter.
  - At zero with `enable` = 1 and the target valid: latch `active_sel` = target, increment the switch count, go to RUN.
  - At zero otherwise: go to IDLE.
- **RUN:** `design_rst_n[active_sel]` = 1, all others 0. `io_out` and `io_oeb` are the `active_sel` slice of the design buses.
  - A CTRL write with a different `req_sel`, or with `enable` = 0, goes to DRAIN.
  - A CTRL write with the same `req_sel` and `enable` = 1 is a no-op.

Other rules:
- `sel_err` is cleared by any valid CTRL write.
- The switch count wraps at 16 bits.
- Reset mid-operation forces IDLE immediately (asynchronous). All registers return to reset values: CTRL = 0, SETTINGS = 0, SETTLE = SETTLE_RST, counts = 0.

## Timing
- **Ack:** `wbs_ack_o` rises one cycle after `cyc & stb` and is held for one cycle; it is registered as `cyc & stb & ~ack`.
- **Read data:** `wbs_dat_o` is registered and valid with ack; it is 0 otherwise.
- **Write effect:** register contents update on the ack edge. The FSM reacts on the following edge.
- **Switch latency:** from the ack of a CTRL write in RUN:
  - the old reset asserts and the pads tri-state 1 cycle later;
  - DRAIN lasts exactly SETTLE cycles;
  - the new `design_rst_n` bit rises and pad muxing starts on the same edge.
- **Register outputs:** `design_rst_n`, `io_oeb`, `active_sel` and `running` are registered, so the pad muxing is glitch-free. `io_out` is combinational from the registered `active_sel` gated by `running`.
- **Reset values:** `wbs_ack_o` = 0, `wbs_dat_o` = 0, `design_rst_n` = 0, `io_out` = 0, `io_oeb` = all 1, `custom_settings` = 0, `active_sel` = 0, `running` = 0.

## Structure
- Package `design_mux_pkg` holds:
  - register offsets `REG_CTRL`, `REG_SETTINGS`, `REG_SETTLE`, `REG_STATUS`;
  - field bit positions;
  - the FSM state enum.
- One sub-module, `design_mux_wb_regs`: Wishbone decode, ack generation, byte-enabled registers and read mux. It emits a `ctrl_wr` pulse to the FSM.
- The FSM, settle counter and pad mux stay in the top module.

## Test plan
- **Reset state:** reset, then read STATUS → 0x0000_0000. `io_oeb` = all 1; all `design_rst_n` = 0.
- **First enable:** SETTLE = 4, write CTRL = 0x102 → DRAIN for exactly 4 cycles. Then `design_rst_n` = 4'b0100, `running` = 1, and `io_out` follows design 2.
- **Switch:** in RUN on design 2, write CTRL = 0x101 → pads tri-state 1 cycle after ack, 4 cycles DRAIN, then design 1 running. STATUS[31:16] = 2.
- **Invalid select:** write CTRL = 0x10F with NUM_DESIGNS = 4 → stays IDLE, STATUS[10] = 1. Then write CTRL = 0x100 → `sel_err` clears and design 0 runs.
- **Byte enables:** write SETTINGS 0xDEADBEEF with `sel` = 4'b0101 → reads 0x00AD00EF. An access at 0x3000_0100 gets no ack within 8 cycles.
- **Edge cases:** a CTRL rewrite mid-DRAIN restarts the full settle count. Asserting `rst_n` mid-DRAIN → IDLE the same cycle, with `design_rst_n` = 0.
